rr_arb_4_1: RTL and testbench

// - Round-robin arbiter and output register for four 4-bit-style sources.
// - Selects one requesting source per cycle, produces the 2-bit select code
//   and the registered data word for the downstream 4:1 mux stage.
// - Uses a valid/ready handshake on every input and on the output.
// - Sustains one transfer per cycle, with fair rotation among active sources.
//

---
 rtl/rr_arb_4_1.sv | 112 +++++++++++
 tb/tb_rr_arb_4_1.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb_4_1.sv
// Four-source round-robin arbiter with a one-word output register (valid/ready on all sides).
// Optional per-source saturating grant counters are enabled with `define RR_ARB_CNT_EN.
module rr_arb_4_1 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel
`ifdef RR_ARB_CNT_EN
  ,
  output logic [3:0][7:0] grant_cnt
`endif
);

  // Returns {found, index} of the first request at or above prio, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] prio);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = prio + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef RR_ARB_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction
`endif

  logic [1:0]   r_prio_p1;
  logic         r_vld_p1;
  logic [W-1:0] r_data_p1;
  logic [1:0]   r_sel_p1;

  logic [2:0]   w_pick_p0;
  logic         w_found_p0;
  logic [1:0]   w_idx_p0;
  logic         w_load_p0;
  logic         w_take_p0;
  logic [W-1:0] w_data_p0;

  // ---- stage p0: combinational pick and source mux ----
  assign w_pick_p0  = rr_pick(in_valid, r_prio_p1);
  assign w_found_p0 = w_pick_p0[2];
  assign w_idx_p0   = w_pick_p0[1:0];
  assign w_load_p0  = ~r_vld_p1 | out_ready;
  assign w_take_p0  = w_load_p0 & w_found_p0;

  always_comb begin
    w_data_p0 = d0;
    case (w_idx_p0)
      2'd0: w_data_p0 = d0;
      2'd1: w_data_p0 = d1;
      2'd2: w_data_p0 = d2;
      2'd3: w_data_p0 = d3;
      default: w_data_p0 = d0;
    endcase
  end

  // Gated by rst_n so the grant is withdrawn the moment reset asserts.
  assign in_ready = (rst_n & w_take_p0) ? (4'b0001 << w_idx_p0) : 4'b0000;

  // ---- stage p1: output register and priority pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_sel_p1  <= 2'd0;
      r_prio_p1 <= 2'd0;
    end else if (w_load_p0) begin
      if (w_found_p0) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= w_data_p0;
        r_sel_p1  <= w_idx_p0;
        r_prio_p1 <= w_idx_p0 + 2'd1;
      end else begin
        r_vld_p1  <= 1'b0;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_sel   = r_sel_p1;

`ifdef RR_ARB_CNT_EN
  logic [3:0][7:0] r_cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_p1 <= '0;
    end else if (w_take_p0) begin
      r_cnt_p1[w_idx_p0] <= sat_inc8(r_cnt_p1[w_idx_p0]);
    end
  end

  assign grant_cnt = r_cnt_p1;
`endif

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Directed bench for rr_arb_4_1: reset, single source, rotation, wrap, backpressure, drain,
// asynchronous reset mid-transfer and (with RR_ARB_CNT_EN) counter saturation.
module tb_rr_arb_4_1;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_sel;
`ifdef RR_ARB_CNT_EN
  logic [3:0][7:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rr_arb_4_1 #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
`ifdef RR_ARB_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; in_valid = 4'b1111;
    d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_sel",   out_sel,   0);
    check("rst_in_ready",  in_ready,  0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    in_valid = 4'b0000;
    step();

    // Single source
    in_valid = 4'b0100; out_ready = 1'b1;
    #1 check("single_in_ready", in_ready, 4'b0100);
    step();
    check("single_out_valid", out_valid, 1);
    check("single_out_data",  out_data,  4'hc);
    check("single_out_sel",   out_sel,   2);
    in_valid = 4'b1111;
    #1 check("single_prio3", in_ready, 4'b1000);
    step();
    check("pre_rot_sel", out_sel, 3);

    // Rotation from prio 0
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("rot_sel_%0d", i),  out_sel,  i % 4);
      check($sformatf("rot_data_%0d", i), out_data, 4'ha + (i % 4));
    end

    // Wrap: move prio to 3, then request 3 and 0
    in_valid = 4'b0100;
    step();
    in_valid = 4'b1001;
    #1 check("wrap_in_ready3", in_ready, 4'b1000);
    step();
    check("wrap_sel3",  out_sel,  3);
    check("wrap_data3", out_data, 4'hd);
    check("wrap_in_ready0", in_ready, 4'b0001);
    step();
    check("wrap_sel0",  out_sel,  0);
    check("wrap_data0", out_data, 4'ha);

    // Backpressure: load 7 from source 1 (prio becomes 2), then stall
    d1 = 4'h7; in_valid = 4'b0010;
    step();
    check("bp_load_data", out_data, 4'h7);
    d0 = 4'h9; d2 = 4'h5; d3 = 4'h6;
    in_valid = 4'b1111; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
      step();
      check($sformatf("bp_valid_%0d", i), out_valid, 1);
      check($sformatf("bp_data_%0d", i),  out_data,  4'h7);
      check($sformatf("bp_sel_%0d", i),   out_sel,   1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", in_ready, 4'b0100);
    step();
    check("bp_release_sel",  out_sel,  2);
    check("bp_release_data", out_data, 4'h5);

    // Drain: no requests empties the register, data/sel held
    in_valid = 4'b0000;
    #1 check("drain_in_ready", in_ready, 0);
    step();
    check("drain_valid", out_valid, 0);
    check("drain_data",  out_data,  4'h5);
    check("drain_sel",   out_sel,   2);

    // EMPTY loads even with out_ready low
    in_valid = 4'b0001; out_ready = 1'b0;
    #1 check("empty_in_ready", in_ready, 4'b0001);
    step();
    check("empty_load_valid", out_valid, 1);
    check("empty_load_sel",   out_sel,   0);
    check("empty_load_data",  out_data,  4'h9);

    // Asynchronous reset while FULL
    in_valid = 4'b1111; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid",    out_valid, 0);
    check("arst_sel",      out_sel,   0);
    check("arst_data",     out_data,  0);
    check("arst_in_ready", in_ready,  0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst_prio0", in_ready, 4'b0001);

`ifdef RR_ARB_CNT_EN
    for (int i = 0; i < 4; i++) check($sformatf("cnt_rst_%0d", i), grant_cnt[i], 0);
    in_valid = 4'b0010;
    for (int i = 0; i < 300; i++) step();
    check("cnt_sat_1", grant_cnt[1], 255);
    check("cnt_0", grant_cnt[0], 0);
    check("cnt_2", grant_cnt[2], 0);
    check("cnt_3", grant_cnt[3], 0);
`endif

    in_valid = 4'b0000;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
